// File: rtl/mem_io_bridge_if.sv
// CPU byte-bus bundle between the CPU core and mem_io_bridge.
// master: CPU side (drives address/write/data, receives read data and run enable).
// slave:  bridge side.
interface mem_io_bridge_if;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;

  modport master (
    output cpu_a,
    output cpu_wr,
    output cpu_dout,
    input  cpu_din,
    input  cpu_rdy
  );

  modport slave (
    input  cpu_a,
    input  cpu_wr,
    input  cpu_dout,
    output cpu_din,
    output cpu_rdy
  );
endinterface

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: decodes CPU byte-bus cycles to the 128 KB synchronous RAM or
// to the IO space at cpu_a[17:16]==2'b11. IO space holds the UART TX FIFO
// (0x30000 write), RX read port (0x30000 read), stop handshake (0x30004 write)
// and, when IO_CYCLE_COUNTER_EN is defined, the free-running cycle counter
// with its byte snapshot (0x30004..0x30007 read). Without the macro those
// reads return 0x00. cpu_rdy stalls the CPU whenever a cycle cannot be served.
module mem_io_bridge #(
  parameter int unsigned TX_FIFO_DEPTH = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  mem_io_bridge_if.slave        cpu,
  output logic                  ram_en,
  output logic                  ram_wr,
  output logic [16:0]           ram_a,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_pop,
  output logic                  program_done
);

  localparam int unsigned AW = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STOP,
    ST_DONE
  } stop_state_t;

  stop_state_t   state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] tx_count;
  logic [7:0]    tx_mem [TX_FIFO_DEPTH];

  logic          accept;
  logic          is_io;
  logic [15:0]   io_off;
  logic          io_rd;
  logic          io_wr;
  logic          tx_push;
  logic          tx_pop;
  logic          stop_req;
  logic [7:0]    push_data;
  logic [7:0]    io_rd_val;
  logic          sel_ram_q;
  logic [7:0]    io_q;
  logic          unused_addr;

`ifdef IO_CYCLE_COUNTER_EN
  logic [31:0]   cycle_cnt;
  logic [31:0]   snap;
`endif

  assign unused_addr = ^cpu.cpu_a[31:18];

  // Run enable: low in reset, once stop is requested, or while the FIFO is full.
  assign cpu.cpu_rdy = rst_in & (state == ST_RUN) & (tx_count < CW'(TX_FIFO_DEPTH));
  assign accept      = cpu.cpu_rdy;

  assign is_io  = (cpu.cpu_a[17:16] == 2'b11);
  assign io_off = cpu.cpu_a[15:0];
  assign io_rd  = accept & is_io & ~cpu.cpu_wr;
  assign io_wr  = accept & is_io & cpu.cpu_wr;

  assign ram_en    = accept & ~is_io;
  assign ram_wr    = ram_en & cpu.cpu_wr;
  assign ram_a     = ram_en ? cpu.cpu_a[16:0] : '0;
  assign ram_wdata = ram_en ? cpu.cpu_dout : '0;

  assign stop_req  = io_wr & (io_off == 16'h0004);
  assign tx_push   = (io_wr & (io_off == 16'h0000) & (cpu.cpu_dout != 8'h00)) | stop_req;
  assign push_data = stop_req ? 8'h00 : cpu.cpu_dout;
  assign tx_valid  = (tx_count != '0);
  assign tx_pop    = tx_valid & tx_ready;
  assign tx_data   = tx_mem[rd_ptr];

  assign rx_pop = io_rd & (io_off == 16'h0000) & rx_valid;

  // IO read mux for the current bus cycle.
  always_comb begin
    io_rd_val = '0;
    case (io_off)
      16'h0000: io_rd_val = rx_valid ? rx_data : 8'h00;
`ifdef IO_CYCLE_COUNTER_EN
      16'h0004: io_rd_val = cycle_cnt[7:0];
      16'h0005: io_rd_val = snap[15:8];
      16'h0006: io_rd_val = snap[23:16];
      16'h0007: io_rd_val = snap[31:24];
`endif
      default:  io_rd_val = '0;
    endcase
  end

  // FIFO storage; contents need no reset because tx_count gates visibility.
  always_ff @(posedge clk_in) begin
    if (tx_push) begin
      tx_mem[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // Stop handshake: sticky stop request, done once the FIFO has drained.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= ST_RUN;
      program_done <= 1'b0;
    end else begin
      case (state)
        ST_RUN:  if (stop_req) state <= ST_STOP;
        ST_STOP: if (tx_count == '0) begin
                   state        <= ST_DONE;
                   program_done <= 1'b1;
                 end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_RUN;
      endcase
    end
  end

  // Read return path: remembers the source of the last accepted read.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sel_ram_q <= 1'b0;
      io_q      <= '0;
    end else if (accept) begin
      if (!cpu.cpu_wr) begin
        sel_ram_q <= ~is_io;
        io_q      <= is_io ? io_rd_val : 8'h00;
      end else begin
        sel_ram_q <= 1'b0;
        io_q      <= '0;
      end
    end
  end

  assign cpu.cpu_din = sel_ram_q ? ram_rdata : io_q;

`ifdef IO_CYCLE_COUNTER_EN
  // Free-running cycle counter; a read of 0x30004 freezes it into snap so the
  // upper bytes read afterwards belong to the same sample.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cycle_cnt <= '0;
      snap      <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (io_rd && (io_off == 16'h0004)) begin
        snap <= cycle_cnt;
      end
    end
  end
`endif

endmodule
